// File: rtl/snes_input_arbiter_if.sv
// rtl/snes_input_arbiter_if.sv - source/select/latch bus between the input front-ends and the SNES arbiter
interface snes_input_arbiter_if #(
   parameter int N_SRC = 3,
   parameter int WIDTH = 16
) ();
   localparam int SW = (N_SRC > 2) ? $clog2(N_SRC) : 1;

   logic [N_SRC*WIDTH-1:0] src_data;
   logic                   auto_mode;
   logic [SW-1:0]          sel;
   logic                   latch;
   logic [WIDTH-1:0]       snes_data;
   logic [SW-1:0]          owner;
   logic                   owner_valid;

   modport master (
      output src_data, auto_mode, sel, latch,
      input  snes_data, owner, owner_valid
   );

   modport slave (
      input  src_data, auto_mode, sel, latch,
      output snes_data, owner, owner_valid
   );
endinterface

// File: rtl/snes_input_arbiter.sv
// rtl/snes_input_arbiter.sv - manual/auto ownership arbiter feeding a latch-frozen SNES button word
// Define SNES_ARB_SYNC_EN to pass every source word through a two-flop synchroniser.
module snes_input_arbiter #(
   parameter int N_SRC       = 3,
   parameter int WIDTH       = 16,
   parameter int HOLD_CYCLES = 1024
) (
   input logic clk,
   input logic reset,
   snes_input_arbiter_if.slave bus
);
   localparam int SW = (N_SRC > 2) ? $clog2(N_SRC) : 1;
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_CYCLES);
   localparam logic [SW:0]   N_SRC_W  = (SW + 1)'(N_SRC);

   typedef enum logic {
      ST_IDLE,
      ST_OWNED
   } state_t;

   logic [N_SRC*WIDTH-1:0] src_w;

`ifdef SNES_ARB_SYNC_EN
   logic [N_SRC*WIDTH-1:0] sync1_q, sync1_d;
   logic [N_SRC*WIDTH-1:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = bus.src_data;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign src_w = sync2_q;
`else
   assign src_w = bus.src_data;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    owner_q, owner_d;
   logic             owner_valid_q, owner_valid_d;
   logic [WIDTH-1:0] snes_data_q, snes_data_d;

   logic [N_SRC-1:0] active;
   logic             any_active;
   logic [SW-1:0]    first_idx;
   logic             owner_active;
   logic [WIDTH-1:0] owner_word;
   logic             sel_in_range;

   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         active[i] = |src_w[i*WIDTH +: WIDTH];
      end
   end

   // Out-of-range owner indices match no source, so their word reads as zero.
   always_comb begin
      any_active   = |active;
      first_idx    = '0;
      owner_active = 1'b0;
      owner_word   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            first_idx = SW'(i);
         end
      end
      for (int i = 0; i < N_SRC; i++) begin
         if (owner_q == SW'(i)) begin
            owner_active = active[i];
            owner_word   = src_w[i*WIDTH +: WIDTH];
         end
      end
   end

   assign sel_in_range = ({1'b0, bus.sel} < N_SRC_W);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      owner_d       = owner_q;
      owner_valid_d = owner_valid_q;

      if (!bus.auto_mode) begin
         state_d       = ST_IDLE;
         cnt_d         = '0;
         owner_d       = bus.sel;
         owner_valid_d = sel_in_range;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               owner_valid_d = 1'b0;
               cnt_d         = '0;
               if (any_active) begin
                  state_d       = ST_OWNED;
                  owner_d       = first_idx;
                  owner_valid_d = 1'b1;
               end
            end
            ST_OWNED: begin
               if (owner_active) begin
                  cnt_d = '0;
               end else if (cnt_q == CNT_LAST) begin
                  // Owner stays visible but invalid; re-arbitration waits for IDLE.
                  state_d       = ST_IDLE;
                  cnt_d         = '0;
                  owner_valid_d = 1'b0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d       = ST_IDLE;
               cnt_d         = '0;
               owner_valid_d = 1'b0;
            end
         endcase
      end
   end

   // Latch samples the pre-edge owner so the shifted word is never torn by a handover.
   always_comb begin
      snes_data_d = snes_data_q;
      if (bus.latch) begin
         snes_data_d = owner_valid_q ? owner_word : '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         owner_q       <= '0;
         owner_valid_q <= 1'b0;
         snes_data_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         snes_data_q   <= snes_data_d;
      end
   end

   assign bus.snes_data   = snes_data_q;
   assign bus.owner       = owner_q;
   assign bus.owner_valid = owner_valid_q;
endmodule

// File: tb/tb_snes_input_arbiter.sv
// tb/tb_snes_input_arbiter.sv - vector table, corner sequences and randomized model check for snes_input_arbiter
module tb_snes_input_arbiter;
   localparam int N    = 3;
   localparam int W    = 16;
   localparam int HOLD = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   snes_input_arbiter_if #(.N_SRC(N), .WIDTH(W)) bus ();

   snes_input_arbiter #(.N_SRC(N), .WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] w0;
      logic [15:0] w1;
      logic [15:0] w2;
      logic        auto_m;
      logic [1:0]  sel;
      logic        latch;
      logic [15:0] e_snes;
      logic [1:0]  e_owner;
      logic        e_valid;
   } vec_t;

   vec_t vt[27];

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                        input logic am, input logic [1:0] s, input logic l);
      bus.src_data  = {w2, w1, w0};
      bus.auto_mode = am;
      bus.sel       = s;
      bus.latch     = l;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input int e_snes, input int e_owner, input int e_valid);
      check({tag, " snes_data"}, int'(bus.snes_data), e_snes);
      check({tag, " owner"}, int'(bus.owner), e_owner);
      check({tag, " owner_valid"}, int'(bus.owner_valid), e_valid);
   endtask

   // Reference model state, described in terms of ownership and run length of zero cycles.
   bit          m_owned;
   int          m_owner;
   bit          m_valid;
   int          m_zero;
   logic [15:0] m_snes;

   task automatic model_reset();
      m_owned = 0;
      m_owner = 0;
      m_valid = 0;
      m_zero  = 0;
      m_snes  = '0;
   endtask

   task automatic model_edge(input logic [15:0] w[3], input bit am, input int s, input bit l);
      int first;
      if (l) m_snes = (m_valid && m_owner < N) ? w[m_owner] : 16'h0;
      if (!am) begin
         m_owned = 0;
         m_zero  = 0;
         m_owner = s;
         m_valid = (s < N);
      end else if (!m_owned) begin
         first = -1;
         for (int i = N - 1; i >= 0; i--) if (w[i] != 0) first = i;
         m_valid = 0;
         if (first >= 0) begin
            m_owned = 1;
            m_owner = first;
            m_valid = 1;
            m_zero  = 0;
         end
      end else if (w[m_owner] != 0) begin
         m_zero = 0;
      end else begin
         m_zero++;
         if (m_zero == HOLD) begin
            m_owned = 0;
            m_valid = 0;
            m_zero  = 0;
         end
      end
   endtask

   initial begin
      logic [15:0] rw[3];
      bit          ram;
      int          rsel;
      bit          rl;

      n_checks = 0;
      n_fail   = 0;

      //        w0        w1        w2       auto sel  latch  snes      owner valid
      vt[0]  = '{16'h0001, 16'h0002, 16'h0004, 1'b0, 2'd1, 1'b0, 16'h0000, 2'd1, 1'b1};
      vt[1]  = '{16'h0001, 16'h0002, 16'h0004, 1'b0, 2'd1, 1'b1, 16'h0002, 2'd1, 1'b1};
      vt[2]  = '{16'h0001, 16'h0002, 16'h0004, 1'b0, 2'd3, 1'b0, 16'h0002, 2'd3, 1'b0};
      vt[3]  = '{16'h0001, 16'h0002, 16'h0004, 1'b0, 2'd3, 1'b1, 16'h0000, 2'd3, 1'b0};
      vt[4]  = '{16'h0001, 16'h0002, 16'h0004, 1'b0, 2'd2, 1'b1, 16'h0000, 2'd2, 1'b1};
      vt[5]  = '{16'h0001, 16'h0002, 16'h0004, 1'b0, 2'd2, 1'b1, 16'h0004, 2'd2, 1'b1};
      vt[6]  = '{16'h0000, 16'h0000, 16'h0000, 1'b1, 2'd0, 1'b0, 16'h0004, 2'd2, 1'b0};
      vt[7]  = '{16'h0011, 16'h0000, 16'h0022, 1'b1, 2'd0, 1'b1, 16'h0000, 2'd0, 1'b1};
      vt[8]  = '{16'h0011, 16'h0000, 16'h0022, 1'b1, 2'd0, 1'b1, 16'h0011, 2'd0, 1'b1};
      vt[9]  = '{16'h0000, 16'h0000, 16'h0022, 1'b1, 2'd0, 1'b1, 16'h0000, 2'd0, 1'b1};
      vt[10] = '{16'h0000, 16'h0000, 16'h0022, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1};
      vt[11] = '{16'h0000, 16'h0000, 16'h0022, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1};
      vt[12] = '{16'h00FF, 16'h0000, 16'h0022, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1};
      vt[13] = '{16'h0000, 16'h0000, 16'h8000, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1};
      vt[14] = '{16'h0000, 16'h0000, 16'h8000, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1};
      vt[15] = '{16'h0000, 16'h0000, 16'h8000, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1};
      vt[16] = '{16'h0000, 16'h0000, 16'h8000, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b0};
      vt[17] = '{16'h0000, 16'h0000, 16'h8000, 1'b1, 2'd0, 1'b1, 16'h0000, 2'd2, 1'b1};
      vt[18] = '{16'h0000, 16'h0000, 16'h8000, 1'b1, 2'd0, 1'b1, 16'h8000, 2'd2, 1'b1};
      vt[19] = '{16'h0000, 16'h0000, 16'h00FF, 1'b1, 2'd0, 1'b1, 16'h00FF, 2'd2, 1'b1};
      vt[20] = '{16'h0000, 16'h0000, 16'h0F00, 1'b1, 2'd0, 1'b0, 16'h00FF, 2'd2, 1'b1};
      vt[21] = '{16'h0000, 16'h0000, 16'h0F00, 1'b1, 2'd0, 1'b0, 16'h00FF, 2'd2, 1'b1};
      vt[22] = '{16'h0000, 16'h0000, 16'h0F00, 1'b1, 2'd0, 1'b1, 16'h0F00, 2'd2, 1'b1};
      vt[23] = '{16'h0000, 16'h0000, 16'h0F00, 1'b0, 2'd1, 1'b1, 16'h0F00, 2'd1, 1'b1};
      vt[24] = '{16'h0000, 16'h0000, 16'h0F00, 1'b0, 2'd1, 1'b1, 16'h0000, 2'd1, 1'b1};
      vt[25] = '{16'h0000, 16'h0003, 16'h0F00, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd1, 1'b1};
      vt[26] = '{16'h0000, 16'h0003, 16'h0F00, 1'b1, 2'd0, 1'b1, 16'h0003, 2'd1, 1'b1};

      reset = 1'b1;
      drive(16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0);
      #12;
      reset = 1'b0;
      #1;
      check_outs("reset", 0, 0, 0);

      for (int i = 0; i < 27; i++) begin
         drive(vt[i].w0, vt[i].w1, vt[i].w2, vt[i].auto_m, vt[i].sel, vt[i].latch);
         tick();
         check_outs($sformatf("vec%0d", i), int'(vt[i].e_snes), int'(vt[i].e_owner), int'(vt[i].e_valid));
      end

      // Asynchronous reset while source 1 owns and its word is on the output.
      drive(16'h0, 16'h0010, 16'h0, 1'b1, 2'd0, 1'b0);
      tick();
      drive(16'h0, 16'h0010, 16'h0, 1'b1, 2'd0, 1'b1);
      tick();
      check_outs("pre_reset", 16'h0010, 1, 1);
      drive(16'h0, 16'h0010, 16'h0, 1'b1, 2'd0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      check_outs("async_reset", 0, 0, 0);
      #1;
      reset = 1'b0;
      tick();
      check_outs("post_reset_arb", 0, 1, 1);

      // Randomized run against the reference model from a fresh reset.
      #3;
      reset = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) rw[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
         ram  = ($urandom_range(0, 9) != 0);
         rsel = $urandom_range(0, 3);
         rl   = ($urandom_range(0, 2) == 0);
         drive(rw[0], rw[1], rw[2], ram, 2'(rsel), rl);
         model_edge(rw, ram, rsel, rl);
         tick();
         check_outs($sformatf("rand%0d", c), int'(m_snes), m_owner, int'(m_valid));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/snes_input_arbiter.md
# snes_input_arbiter

Parametrised, clocked successor to the SNES controller data-input multiplexer. It selects one of N_SRC button-word sources (keyboard, push-buttons, IR, …) either manually or automatically by activity ownership, and presents the selected word to the SNES translator. The output is frozen between console latch pulses so the word stays stable while it is shifted out.

## Interface
- N_SRC, 3: number of input sources, 2..8.
- WIDTH, 16: bits per button word; a bit at 1 means pressed.
- HOLD_CYCLES, 1024: consecutive all-zero cycles before an owner is released in auto mode; minimum 1.
- SW, $clog2(N_SRC) (minimum 1): select and owner width, derived and not overridable.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- src_data  in  N_SRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH].
- auto_mode  in  1  1 = ownership arbitration; 0 = manual select.
- sel  in  SW  manual source index, used only when auto_mode = 0.
- latch  in  1  one-cycle pulse marking the console latch; updates snes_data.
- snes_data  out  WIDTH  registered word for the translator.
- owner  out  SW  current owning source index.
- owner_valid  out  1  1 when owner is meaningful.

## Operation
- Reset values: snes_data = 0, owner = 0, owner_valid = 0, state = IDLE, hold counter = 0.
- "Active" for source i means its word (after the optional synchroniser) is non-zero.
- Manual mode (auto_mode = 0):
  - state is forced to IDLE and the counter is cleared.
  - owner = sel, registered every cycle.
  - owner_valid = 1 when sel < N_SRC, otherwise 0.
- Auto mode (auto_mode = 1). State machine:
  - IDLE: owner_valid = 0. If any source is active, go to OWNED with owner = the lowest active index, owner_valid = 1, counter = 0.
  - OWNED, owner active: counter = 0, stay in OWNED. Activity on any other source is ignored.
  - OWNED, owner all-zero: counter increments. On the edge where the counter would reach HOLD_CYCLES, go to IDLE, clear the counter, keep the owner value and set owner_valid = 0.
- Auto-mode boundaries:
  - Re-arbitration happens no earlier than the cycle after the return to IDLE.
  - The counter saturates and never wraps.
- Toggling auto_mode takes effect on the next edge. 1→0 drops ownership immediately. 0→1 starts from IDLE.
- Output update: on an edge with latch = 1, snes_data ← src_data word of the pre-edge owner if owner_valid was 1, else 0. Without latch, snes_data holds its value.
- An out-of-range index never reads src_data; the output is 0.
- Reset asserted mid-frame returns every output to its reset value immediately, independent of clk.

## Timing
- Ownership decision: 1 cycle after a source becomes active (IDLE→OWNED on the next edge).
- Data path: the latch edge samples the registered owner, so a source that first becomes active in the cycle before latch yields 0 for that frame and is output on the next latch.
- Release: exactly HOLD_CYCLES edges of continuous zero after the last active cycle.
- latch held high for several cycles: snes_data reloads on each of those edges.

## Configuration
- SNES_ARB_SYNC_EN defined:
  - Each source word passes through a two-flop synchroniser (reset to 0) before activity detection and output selection.
  - All src_data-to-decision and src_data-to-snes_data latencies increase by 2 cycles.
- SNES_ARB_SYNC_EN undefined: src_data is used directly. For sources already in the clk domain.

## Test plan
- Reset mid-operation. Setup: auto_mode = 1, source 1 = 16'h0010 owning, then reset pulsed between clock edges. Required: snes_data = 0, owner_valid = 0 immediately; after release, IDLE re-arbitrates normally.
- Manual select. Setup: auto_mode = 0, N_SRC = 3, words 16'h0001 / 16'h0002 / 16'h0004.
  - sel = 1, latch pulse → snes_data = 16'h0002.
  - sel = 3, latch pulse → snes_data = 0 and owner_valid = 0.
- Simultaneous activity. Setup: auto mode, sources 0 and 2 become non-zero in the same cycle. Required: owner = 0 on the next edge; on later latches source 2's word is never output while source 0 owns.
- Hold release. Setup: HOLD_CYCLES = 4; the owner goes to zero while source 2 = 16'h8000.
  - After 4 zero edges: IDLE, owner_valid = 0.
  - Next edge: owner = 2.
  - Next latch: snes_data = 16'h8000.
  - A non-zero owner word at zero-count 3 restarts the count.
- Latch freeze. Setup: owner word changes 16'h00FF→16'h0F00 between latch pulses. Required: snes_data stays 16'h00FF until the next latch edge, then shows 16'h0F00.
